// File: rtl/beam_power_trigger_if.sv
// Bus bundle for beam_power_trigger: sample data, threshold load, trigger outputs.
// Latency: none (wires only).
// Backpressure: none, fixed-latency stream with no handshake.
//
// Ports carried:
//   data_i          [320]       8 channels x 8 samples x 5-bit signed AGC data
//   thresh_i        [36]        two 18-bit threshold values (set 0 low, set 1 high)
//   thresh_wr_i     [2]         shift thresh_i into the pending chain of set k
//   thresh_update_i [2]         copy pending -> active for set k
//   trigger_o       [2*NBEAMS]  trigger_o[k*NBEAMS+b]
//   power_o         [NBEAMS*18] only when POWER_OUT_EN is defined
interface beam_power_trigger_if #(
    parameter int NBEAMS = 2
);
    localparam int DATA_W = 8 * 8 * 5;

    logic [DATA_W-1:0]     data_i;
    logic [35:0]           thresh_i;
    logic [1:0]            thresh_wr_i;
    logic [1:0]            thresh_update_i;
    logic [2*NBEAMS-1:0]   trigger_o;
`ifdef POWER_OUT_EN
    logic [NBEAMS*18-1:0]  power_o;

    modport master (output data_i, thresh_i, thresh_wr_i, thresh_update_i,
                    input  trigger_o, power_o);
    modport slave  (input  data_i, thresh_i, thresh_wr_i, thresh_update_i,
                    output trigger_o, power_o);
`else
    modport master (output data_i, thresh_i, thresh_wr_i, thresh_update_i,
                    input  trigger_o);
    modport slave  (input  data_i, thresh_i, thresh_wr_i, thresh_update_i,
                    output trigger_o);
`endif
endinterface

// File: rtl/beam_power_trigger.sv
// Per-beam power trigger: delay-and-sum 8 channels into NBEAMS beams, square, integrate, compare.
// Latency: data_i sampled at edge n reaches trigger_o after edge n+4 (E0..E4 all registered).
// Backpressure: none; one 8-sample block accepted every clock.
//
// Ports: clk_i (trigger clock), rst_i (async active-high), bus (beam_power_trigger_if.slave):
//   data_i, thresh_i, thresh_wr_i, thresh_update_i in; trigger_o out.
// Optional macro POWER_OUT_EN: adds bus.power_o, the E3 power register of each beam.
// ZERO_IS_FAKE = "TRUE" forces trigger_o[k][0] low (beam 0 is not a real beam).
module beam_power_trigger #(
    parameter int NBEAMS       = 2,
    parameter     ZERO_IS_FAKE = "TRUE"
) (
    input logic                 clk_i,
    input logic                 rst_i,
    beam_power_trigger_if.slave bus
);
    localparam int NCHAN    = 8;
    localparam int NSAMP    = 8;
    localparam int AGC_BITS = 5;
    localparam int THR_W    = 18;
    localparam bit FAKE0    = (ZERO_IS_FAKE == "TRUE");

    function automatic logic signed [7:0] sext8(input logic signed [AGC_BITS-1:0] x);
        return {{(8-AGC_BITS){x[AGC_BITS-1]}}, x};
    endfunction

    // Square of an 8-bit signed beam sample; at most 128^2, fits 16 bits unsigned.
    function automatic logic [15:0] square(input logic signed [7:0] x);
        logic signed [15:0] w;
        w = {{8{x[7]}}, x};
        return w * w;
    endfunction

    // E0: current and previous sample blocks per channel.
    logic signed [AGC_BITS-1:0] cur_q  [NCHAN][NSAMP];
    logic signed [AGC_BITS-1:0] prev_q [NCHAN][NSAMP];
    // 16-deep history: 0..7 previous block, 8..15 current block.
    logic signed [AGC_BITS-1:0] hist   [NCHAN][2*NSAMP];

    logic signed [7:0]       beam_sum [NBEAMS][NSAMP];
    logic signed [7:0]       beam_q   [NBEAMS][NSAMP];   // E1
    logic        [15:0]      sq_q     [NBEAMS][NSAMP];   // E2
    logic        [THR_W-1:0] psum     [NBEAMS];
    logic        [THR_W-1:0] pwr_q    [NBEAMS];          // E3
    logic        [THR_W-1:0] pend_q   [2][NBEAMS];
    logic        [THR_W-1:0] act_q    [2][NBEAMS];
    logic        [2*NBEAMS-1:0] trig_q;                  // E4

    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            for (int s = 0; s < NSAMP; s++) begin
                hist[c][s]         = prev_q[c][s];
                hist[c][s + NSAMP] = cur_q[c][s];
            end
        end
    end

    // Channel c of beam b is delayed by (b*c) mod 8 samples, reaching back
    // into the previous block when the delay exceeds the sample index.
    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        for (genvar s = 0; s < NSAMP; s++) begin : g_samp
            logic signed [7:0] tap [NCHAN];
            logic signed [7:0] acc;
            for (genvar c = 0; c < NCHAN; c++) begin : g_tap
                assign tap[c] = sext8(hist[c][NSAMP + s - ((b * c) % NSAMP)]);
            end
            // 8 x [-16,15] stays within [-128,120]: no overflow in 8 bits.
            always_comb begin
                acc = '0;
                for (int c = 0; c < NCHAN; c++) acc = acc + tap[c];
            end
            assign beam_sum[b][s] = acc;
        end
    end

    always_comb begin
        for (int b = 0; b < NBEAMS; b++) begin
            psum[b] = '0;
            for (int s = 0; s < NSAMP; s++) psum[b] = psum[b] + {2'b00, sq_q[b][s]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCHAN; c++) begin
                for (int s = 0; s < NSAMP; s++) begin
                    cur_q[c][s]  <= '0;
                    prev_q[c][s] <= '0;
                end
            end
            for (int b = 0; b < NBEAMS; b++) begin
                for (int s = 0; s < NSAMP; s++) begin
                    beam_q[b][s] <= '0;
                    sq_q[b][s]   <= '0;
                end
                pwr_q[b] <= '0;
            end
            // All-ones exceeds any reachable power, so nothing triggers until loaded.
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < NBEAMS; b++) begin
                    pend_q[k][b] <= '1;
                    act_q[k][b]  <= '1;
                end
            end
            trig_q <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                for (int s = 0; s < NSAMP; s++) begin
                    cur_q[c][s]  <= bus.data_i[(c*NSAMP + s)*AGC_BITS +: AGC_BITS];
                    prev_q[c][s] <= cur_q[c][s];
                end
            end
            for (int b = 0; b < NBEAMS; b++) begin
                for (int s = 0; s < NSAMP; s++) begin
                    beam_q[b][s] <= beam_sum[b][s];
                    sq_q[b][s]   <= square(beam_q[b][s]);
                end
                pwr_q[b] <= psum[b];
            end
            // Non-blocking update reads the pre-shift pending chain, so a
            // same-cycle write and update activates the old pending values.
            for (int k = 0; k < 2; k++) begin
                if (bus.thresh_update_i[k]) begin
                    for (int b = 0; b < NBEAMS; b++) act_q[k][b] <= pend_q[k][b];
                end
                if (bus.thresh_wr_i[k]) begin
                    for (int b = 0; b < NBEAMS - 1; b++) pend_q[k][b] <= pend_q[k][b+1];
                    pend_q[k][NBEAMS-1] <= bus.thresh_i[k*THR_W +: THR_W];
                end
            end
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < NBEAMS; b++) begin
                    trig_q[k*NBEAMS + b] <= (FAKE0 && b == 0) ? 1'b0
                                          : (pwr_q[b] > act_q[k][b]);
                end
            end
        end
    end

    assign bus.trigger_o = trig_q;

`ifdef POWER_OUT_EN
    for (genvar b = 0; b < NBEAMS; b++) begin : g_pwr_out
        assign bus.power_o[b*THR_W +: THR_W] = pwr_q[b];
    end
`endif
endmodule

// File: tb/tb_beam_power_trigger.sv
// Directed bench for beam_power_trigger: one instance with beam 0 faked, one without.
// Latency: expectations are taken 1 time unit after each rising edge.
// Backpressure: none; inputs are driven 1 time unit after the edge.
module tb_beam_power_trigger;
    localparam int NBEAMS = 2;

    bit   clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    beam_power_trigger_if #(.NBEAMS(NBEAMS)) if_t ();
    beam_power_trigger_if #(.NBEAMS(NBEAMS)) if_f ();

    assign if_f.data_i          = if_t.data_i;
    assign if_f.thresh_i        = if_t.thresh_i;
    assign if_f.thresh_wr_i     = if_t.thresh_wr_i;
    assign if_f.thresh_update_i = if_t.thresh_update_i;

    beam_power_trigger #(.NBEAMS(NBEAMS), .ZERO_IS_FAKE("TRUE"))
        dut_t (.clk_i(clk), .rst_i(rst), .bus(if_t));
    beam_power_trigger #(.NBEAMS(NBEAMS), .ZERO_IS_FAKE("FALSE"))
        dut_f (.clk_i(clk), .rst_i(rst), .bus(if_f));

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check both instances; trigger words are {set1[b1,b0], set0[b1,b0]}.
    task automatic chk2(input string tag, input logic [3:0] exp_t, input logic [3:0] exp_f);
        chk({tag, "_t"}, {32'd0, if_t.trigger_o}, {32'd0, exp_t});
        chk({tag, "_f"}, {32'd0, if_f.trigger_o}, {32'd0, exp_f});
    endtask

    task automatic wr(input int k, input logic [17:0] v, input bit upd);
        if_t.thresh_i[k*18 +: 18] = v;
        if_t.thresh_wr_i[k]       = 1'b1;
        if_t.thresh_update_i[k]   = upd;
        tick();
        if_t.thresh_wr_i     = '0;
        if_t.thresh_update_i = '0;
    endtask

    task automatic upd(input int k);
        if_t.thresh_update_i[k] = 1'b1;
        tick();
        if_t.thresh_update_i = '0;
    endtask

    task automatic load(input int k, input logic [17:0] b0, input logic [17:0] b1);
        wr(k, b0, 1'b0);
        wr(k, b1, 1'b0);
        upd(k);
    endtask

    function automatic logic [319:0] fill(input logic [4:0] v);
        logic [319:0] d;
        for (int i = 0; i < 64; i++) d[i*5 +: 5] = v;
        return d;
    endfunction

    // One block of d, then zeros; ef/et hold 4-bit expectations for edges n+1..n+6.
    task automatic impulse(input string tag, input logic [319:0] d,
                           input logic [23:0] et, input logic [23:0] ef);
        if_t.data_i = d;
        tick();
        if_t.data_i = '0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk2($sformatf("%s_n%0d", tag, i), et[(i-1)*4 +: 4], ef[(i-1)*4 +: 4]);
        end
    endtask

    initial begin
        logic [319:0] imp;
        if_t.data_i          = '0;
        if_t.thresh_i        = '0;
        if_t.thresh_wr_i     = '0;
        if_t.thresh_update_i = '0;

        // Reset state, then constant +1 with thresholds never loaded.
        repeat (2) tick();
        chk2("reset", 4'b0000, 4'b0000);
        rst = 1'b0;
        if_t.data_i = fill(5'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk2($sformatf("const_noload_%0d", i), 4'b0000, 4'b0000);
        end
`ifdef POWER_OUT_EN
        chk("power_const_t", {18'd0, if_t.power_o}, {18'd0, 18'd512, 18'd512});
`endif

        // Set 0 = 511 on both beams: power 512 exceeds it.
        wr(0, 18'd511, 1'b0);
        wr(0, 18'd511, 1'b0);
        tick();
        chk2("pend_not_active", 4'b0000, 4'b0000);
        upd(0);
        tick();
        chk2("set0_511", 4'b0010, 4'b0011);

        // Set 1 strict compare: 512 does not trigger, 500 does.
        load(1, 18'd512, 18'd512);
        tick();
        chk2("set1_512", 4'b0010, 4'b0011);
        load(1, 18'd500, 18'd500);
        tick();
        chk2("set1_500", 4'b1010, 4'b1111);

        // Same-cycle write+update activates pre-shift pending {511,600}.
        wr(0, 18'd511, 1'b0);
        wr(0, 18'd600, 1'b0);
        wr(0, 18'd100, 1'b1);
        tick();
        chk2("wr_upd_same", 4'b1000, 4'b1101);
        upd(0);
        tick();
        chk2("upd_shifted", 4'b1010, 4'b1110);

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk2("async_rst", 4'b0000, 4'b0000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk2($sformatf("post_rst_%0d", i), 4'b0000, 4'b0000);
        end
        load(0, 18'd511, 18'd511);
        tick();
        chk2("reload", 4'b0010, 4'b0011);

        // Impulse tests on zero background.
        if_t.data_i = '0;
        load(0, 18'd0, 18'd0);
        repeat (6) tick();
        chk2("zero_data", 4'b0000, 4'b0000);

        imp = '0;
        for (int c = 0; c < 8; c++) imp[c*40 +: 5] = 5'd15;
        // Beam 0: 8*15 in sample 0 -> 14400; beam 1: 15 in each sample -> 1800.
        impulse("imp_thr0", imp, 24'h002000, 24'h003000);
        load(0, 18'd0, 18'd1799);
        impulse("imp_thr1799", imp, 24'h002000, 24'h003000);
        load(0, 18'd0, 18'd1800);
        impulse("imp_thr1800", imp, 24'h000000, 24'h001000);

        // Channel 1, sample 7: beam 1 delays it by one sample into the next block.
        load(0, 18'd0, 18'd0);
        imp = '0;
        imp[1*40 + 7*5 +: 5] = 5'd15;
        impulse("imp_ch1s7", imp, 24'h020000, 24'h021000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
